// File: rtl/instr_encoder.sv
// RV64 instruction encoder: packs decoded fields (I-load/S/B/R) into a 32-bit word,
// flags out-of-range immediates, and streams results through a 2-entry output FIFO.
module instr_encoder #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       fmt,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [63:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;
  localparam logic [1:0] FMT_R = 2'b11;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never waits on ready, and ready here depends only on registered FIFO state.
  logic        push;
  logic        pop;
  logic [1:0]  count;
  logic [31:0] head_inst;
  logic        head_err;
  logic [31:0] tail_inst;
  logic        tail_err;

  logic [31:0] enc_inst;
  logic        enc_err;
  logic        hi11_ok;
  logic        hi12_ok;

  // An immediate fits when everything above the top encoded bit is a sign extension.
  assign hi11_ok = (&imm[63:11]) || (~|imm[63:11]);
  assign hi12_ok = (&imm[63:12]) || (~|imm[63:12]);

  always_comb begin
    enc_inst = 32'd0;
    enc_err  = 1'b0;
    case (fmt)
      FMT_I: begin
        enc_inst = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
        enc_err  = !hi11_ok;
      end
      FMT_S: begin
        enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
        enc_err  = !hi11_ok;
      end
      FMT_B: begin
        enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        enc_err  = !hi12_ok || imm[0];
      end
      FMT_R: begin
        enc_inst = {funct7, rs2, rs1, funct3, rd, OPC_OP};
        enc_err  = 1'b0;
      end
      default: begin
        enc_inst = 32'd0;
        enc_err  = 1'b0;
      end
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_inst  = head_inst;
  assign out_err   = head_err;

  // Head is slot 0; slot 1 only holds data when count is 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_inst <= 32'd0;
      head_err  <= 1'b0;
      tail_inst <= 32'd0;
      tail_err  <= 1'b0;
    end else begin
      if (push && pop) begin
        head_inst <= enc_inst;
        head_err  <= enc_err;
      end else if (push) begin
        if (count == 2'd0) begin
          head_inst <= enc_inst;
          head_err  <= enc_err;
        end else begin
          tail_inst <= enc_inst;
          tail_err  <= enc_err;
        end
        count <= count + 2'd1;
      end else if (pop) begin
        if (count == 2'd2) begin
          head_inst <= tail_inst;
          head_err  <= tail_err;
        end
        count <= count - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (push) begin
      enc_count <= enc_count + CNT_W'(1);
      if (enc_err && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table, backpressure, mid-stream reset,
// random round trip through an immediate decoder model, and counter limits.
module tb_instr_encoder;

  localparam int W = 100; // {mode, fmt[1:0], err, inst[31:0], imm[63:0]}

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  int n_pass;
  int n_total;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic rdy_rand;

  typedef struct {
    logic [1:0]  fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  instr_encoder #(.CNT_W(16), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] decode_imm(input logic [31:0] i, input logic [1:0] f);
    case (f)
      2'b00:   decode_imm = {{52{i[31]}}, i[31:20]};
      2'b01:   decode_imm = {{52{i[31]}}, i[31:25], i[11:7]};
      default: decode_imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endcase
  endfunction

  function automatic logic [6:0] opcode_of(input logic [1:0] f);
    case (f)
      2'b00:   opcode_of = 7'h03;
      2'b01:   opcode_of = 7'h23;
      2'b10:   opcode_of = 7'h63;
      default: opcode_of = 7'h33;
    endcase
  endfunction

  // driver tasks
  task automatic drive(input logic [1:0] f, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [63:0] im);
    fmt = f; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [1:0] f, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [63:0] im, input logic [W-1:0] e);
    bit done;
    done = 0;
    drive(f, f3, f7, d, s1, s2, im);
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    send(v.fmt, v.f3, v.f7, v.rd, v.rs1, v.rs2, v.imm, {1'b0, 2'b00, v.err, v.inst, 64'd0});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_enc_count", 64'(enc_count), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_out_inst", 64'(out_inst), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // scoreboard monitor: the head is consumed at the edge after this sample
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_inst), 64'hdead);
      end else begin
        mon_e = exp_q.pop_front();
        if (!mon_e[99]) begin
          check("out_inst", 64'(out_inst), 64'(mon_e[95:64]));
          check("out_err", 64'(out_err), 64'(mon_e[96]));
        end else begin
          check("rt_err", 64'(out_err), 64'd0);
          check("rt_opcode", 64'(out_inst[6:0]), 64'(opcode_of(mon_e[98:97])));
          check("rt_imm", decode_imm(out_inst, mon_e[98:97]), mon_e[63:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  end

  logic [31:0] r;
  logic [63:0] rimm;
  logic [1:0]  rfmt;
  logic [31:0] hold_inst;

  initial begin
    n_pass = 0; n_total = 0;
    rdy_rand = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = 2'b00; funct3 = 3'd0; funct7 = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 64'd0;

    //           fmt    f3    f7      rd     rs1    rs2    imm                       inst          err
    vecs[0]  = '{2'b00, 3'd1, 7'h7f, 5'd5,  5'd0,  5'd31, 64'hffff_ffff_ffff_ffff, 32'hFFF01283, 1'b0};
    vecs[1]  = '{2'b01, 3'd3, 7'h55, 5'd31, 5'd2,  5'd5,  64'hffff_ffff_ffff_fff8, 32'hFE513C23, 1'b0};
    vecs[2]  = '{2'b10, 3'd0, 7'h01, 5'd9,  5'd0,  5'd0,  64'hffff_ffff_ffff_fffc, 32'hFE000EE3, 1'b0};
    vecs[3]  = '{2'b11, 3'd0, 7'h00, 5'd10, 5'd0,  5'd10, 64'h1234_5678_9abc_def0, 32'h00A00533, 1'b0};
    vecs[4]  = '{2'b00, 3'd3, 7'h00, 5'd1,  5'd0,  5'd0,  64'd2048,                32'h80003083, 1'b1};
    vecs[5]  = '{2'b10, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  64'd3,                   32'h00000163, 1'b1};
    vecs[6]  = '{2'b00, 3'd0, 7'h00, 5'd2,  5'd0,  5'd0,  64'hffff_ffff_ffff_f800, 32'h80000103, 1'b0};
    vecs[7]  = '{2'b01, 3'd2, 7'h00, 5'd0,  5'd1,  5'd2,  64'd2047,                32'h7E20AFA3, 1'b0};
    vecs[8]  = '{2'b01, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  64'hffff_ffff_ffff_f7ff, 32'h7E000FA3, 1'b1};
    vecs[9]  = '{2'b10, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  64'd4094,                32'h7E000FE3, 1'b0};
    vecs[10] = '{2'b10, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  64'd4096,                32'h80000063, 1'b1};
    vecs[11] = '{2'b11, 3'd0, 7'h20, 5'd1,  5'd2,  5'd3,  64'h8000_0000_0000_0000, 32'h403100B3, 1'b0};
    vecs[12] = '{2'b00, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  64'h0000_0001_0000_0000, 32'h00000003, 1'b1};

    #12;
    check("init_out_valid", 64'(out_valid), 64'd0);
    check("init_in_ready", 64'(in_ready), 64'd1);
    check("init_enc_count", 64'(enc_count), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // first request after reset: visible the cycle after its accept edge
    drive(vecs[0].fmt, vecs[0].f3, vecs[0].f7, vecs[0].rd, vecs[0].rs1, vecs[0].rs2, vecs[0].imm);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_enc_count", 64'(enc_count), 64'd1);
    check("lat_out_inst", 64'(out_inst), 64'hFFF01283);
    do_reset();
    out_ready = 1'b1;

    for (int i = 0; i < 4; i++) send_vec(vecs[i]);
    drain();
    check("golden_enc_count", 64'(enc_count), 64'd4);
    check("golden_err_count", 64'(err_count), 64'd0);
    for (int i = 4; i < 7; i++) send_vec(vecs[i]);
    drain();
    check("range_err_count", 64'(err_count), 64'd2);
    for (int i = 7; i < 13; i++) send_vec(vecs[i]);
    drain();
    check("extra_err_count", 64'(err_count), 64'd5);
    check("extra_enc_count", 64'(enc_count), 64'd13);
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // backpressure: three back-to-back requests against a stalled consumer
    out_ready = 1'b0;
    drive(vecs[7].fmt, vecs[7].f3, vecs[7].f7, vecs[7].rd, vecs[7].rs1, vecs[7].rs2, vecs[7].imm);
    @(negedge clk);
    check("bp_ready_c1", 64'(in_ready), 64'd1);
    exp_q.push_back({1'b0, 2'b00, vecs[7].err, vecs[7].inst, 64'd0});
    @(posedge clk); #1;
    drive(vecs[11].fmt, vecs[11].f3, vecs[11].f7, vecs[11].rd, vecs[11].rs1, vecs[11].rs2, vecs[11].imm);
    @(negedge clk);
    check("bp_ready_c2", 64'(in_ready), 64'd1);
    exp_q.push_back({1'b0, 2'b00, vecs[11].err, vecs[11].inst, 64'd0});
    @(posedge clk); #1;
    drive(vecs[8].fmt, vecs[8].f3, vecs[8].f7, vecs[8].rd, vecs[8].rs1, vecs[8].rs2, vecs[8].imm);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(in_ready), 64'd0);
      check("bp_head_stable", 64'(out_inst), 64'h7E20AFA3);
      @(posedge clk); #1;
    end
    check("bp_enc_count", 64'(enc_count), 64'd15);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_at_pop", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("bp_ready_after_pop", 64'(in_ready), 64'd1);
    exp_q.push_back({1'b0, 2'b00, vecs[8].err, vecs[8].inst, 64'd0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    check("bp_enc_count_end", 64'(enc_count), 64'd16);

    // reset mid-stream with two entries buffered
    out_ready = 1'b0;
    send_vec(vecs[1]);
    send_vec(vecs[2]);
    check("mid_full", 64'(in_ready), 64'd0);
    hold_inst = out_inst;
    check("mid_head", 64'(hold_inst), 64'hFE513C23);
    do_reset();
    out_ready = 1'b1;
    send_vec(vecs[0]);
    drain();
    check("post_rst_enc_count", 64'(enc_count), 64'd1);

    // random round trip with random consumer readiness
    rdy_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      r = $urandom;
      rfmt = 2'($urandom_range(0, 2));
      if (rfmt == 2'b10) rimm = {{51{r[12]}}, r[12:1], 1'b0};
      else rimm = {{52{r[11]}}, r[11:0]};
      send(rfmt, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rimm, {1'b1, rfmt, 1'b0, 32'd0, rimm});
    end
    rdy_rand = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    check("rt_enc_count", 64'(enc_count), 64'd201);
    check("rt_err_count", 64'(err_count), 64'd0);

    // counter limits
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 300; n++)
      send(2'b00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd4096, {1'b0, 2'b00, 1'b1, 32'h00000003, 64'd0});
    drain();
    check("err_sat", 64'(err_count), 64'd255);
    check("enc_300", 64'(enc_count), 64'd300);
    for (int n = 300; n < 65536; n++)
      send(2'b11, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0, {1'b0, 2'b00, 1'b0, 32'h00000033, 64'd0});
    drain();
    check("enc_wrap", 64'(enc_count), 64'd0);
    check("err_hold", 64'(err_count), 64'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV64 instruction encoder: accepts decoded fields (format, registers, funct bits, 64-bit signed immediate) and packs them into a 32-bit instruction word, the inverse of `immediate_gen`. It is used by the instruction-memory preload path and by self-checking benches to build programs and round-trip the decoder. The block has valid/ready input and output ports, a 2-entry output buffer, immediate range checking and running statistics counters.

## Interface
- `CNT_W`, default 16: width of the encoded-instruction counter.
- `ERR_W`, default 8: width of the saturating error counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: the input fields are valid.
- `in_ready` out 1: the encoder can accept a request this cycle.
- `fmt` in 2: instruction format.
  - 00 = I-load, opcode 0000011.
  - 01 = S, opcode 0100011.
  - 10 = B, opcode 1100011.
  - 11 = R, opcode 0110011.
- `funct3` in 3: funct3 field.
- `funct7` in 7: funct7 field; used by R only.
- `rd`, `rs1`, `rs2` in 5 each: register indices. A field the format does not use is ignored.
- `imm` in 64: signed immediate / byte offset; ignored for R.
- `out_valid` out 1: `out_inst` and `out_err` are valid.
- `out_ready` in 1: the consumer accepts the head entry.
- `out_inst` out 32: encoded instruction.
- `out_err` out 1: the immediate was out of range or misaligned for this entry.
- `enc_count` out CNT_W: number of accepted requests; wraps modulo 2^CNT_W.
- `err_count` out ERR_W: number of accepted requests flagged as errors; saturates at all-ones.

## Operation
- **Input handshake.** A request is accepted on a rising edge where `in_valid && in_ready`.
- **Encoding (combinational, on accept):**
  - I: `{imm[11:0], rs1, funct3, rd, opcode}`.
  - S: `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`.
  - B: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}`.
  - R: `{funct7, rs2, rs1, funct3, rd, opcode}`.
- **Range check:**
  - I/S: error unless `imm[63:11]` is all-zeros or all-ones.
  - B: error unless `imm[63:12]` is all-zeros or all-ones, and additionally `imm[0]` must be 0.
  - R: never an error.
  - An erroneous request is still encoded from the truncated bits and enqueued with `out_err`=1. It is never dropped.
- **Output buffer:** a 2-entry FIFO of `{inst, err}`.
  - The occupancy count takes values 0..2.
  - `out_valid` = (count != 0).
  - `in_ready` = (count != 2).
  - The head entry drives `out_inst`/`out_err`.
- **Simultaneous push and pop:**
  - count 1: count stays 1 and the new entry becomes the head.
  - count 2: push is impossible because `in_ready` is 0, so the pop alone takes count to 1.
- **Counters:** `enc_count` +1 per accept (wraps). `err_count` +1 per accept with an error; it holds at 2^ERR_W-1.
- **Reset (asynchronous, any time, including mid-stream):**
  - FIFO count 0, so `out_valid` 0 and `in_ready` 1.
  - `out_inst` 0, `out_err` 0, `enc_count` 0, `err_count` 0.
  - Buffered entries are discarded.
- **Illegal-input rule:** no X propagation. Every field is always sampled, whether or not the format uses it.

## Timing
- Latency: a request accepted at edge N appears with `out_valid`=1 after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: 1 request/cycle while `out_ready`=1.
- `in_ready` is a function of registered count only; it has no combinational path from `out_ready` or `in_valid`.
- Backpressure: with `out_ready`=0, at most 2 requests are accepted, then `in_ready` drops. It rises one cycle after the first pop.
- Output ordering is strict FIFO. `out_inst`/`out_err` are stable while `out_valid && !out_ready`.
- Counters update on the accept edge, so they read the new value in cycle N+1.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with 2 entries buffered -> immediately `out_valid`=0, `in_ready`=1, both counters 0. After release, the first request encodes correctly.
- **Golden encodings, `out_ready`=1, out_err=0 each, `enc_count`=4:**
  - I: fmt=00, funct3=1, rd=5, rs1=0, imm=-1 -> 0xFFF01283.
  - S: fmt=01, funct3=3, rs1=2, rs2=5, imm=-8 -> 0xFE513C23.
  - B: fmt=10, funct3=0, rs1=rs2=0, imm=-4 -> 0xFE000EE3.
  - R: fmt=11, funct7=0, funct3=0, rd=10, rs1=0, rs2=10 -> 0x00A00533.
- **Range errors:**
  - I with imm=2048, rd=1, rs1=0, funct3=3 -> 0x80003083 with out_err=1.
  - B with imm=3 -> out_err=1.
  - I with imm=-2048 -> out_err=0.
  - Expect `err_count`=2 afterwards.
- **Backpressure:** hold `out_ready`=0 and drive 3 back-to-back valid requests -> 2 accepted, `in_ready`=0 from cycle 3. Release `out_ready` -> outputs arrive in original order, then the third request is accepted.
- **Round trip:** feed 200 random I/S/B requests with in-range immediates into `instr_encoder`, then into `immediate_gen` -> `imm_out` equals `imm` (B with bit 0 cleared). Random `out_ready` throughout; no loss and no duplication.
- **Counter limits:** 300 erroneous requests -> `err_count` holds at 255. Force 65536 accepts -> `enc_count` wraps to 0.
